eth_frame_tx: RTL

eth_frame_tx builds Ethernet II frames for the transmit path. It accepts a header descriptor (destination MAC, source MAC, EtherType) and a payload AXI-Stream. It emits a single byte stream: the 14-byte header, then the payload, then zero-padding up to the minimum payload length. Its output drives the tx AXI-Stream input (tdata/tvalid/tlast/trdy) of the Ethernet MAC FIFO wrapper and runs in that wrapper's system clock domain.

---
 rtl/eth_frame_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/eth_frame_tx.sv
// Ethernet II transmit framer: 14-byte header from a descriptor, payload pass-through,
// then zero padding up to MIN_PAYLOAD bytes. The FCS is added downstream by the MAC.
module eth_frame_tx #(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MIN_PAYLOAD    = 46,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      s_hdr_valid,
    output logic                      s_hdr_ready,
    input  logic [47:0]               s_hdr_dest_mac,
    input  logic [47:0]               s_hdr_src_mac,
    input  logic [15:0]               s_hdr_eth_type,
    input  logic [AXI_DATA_WIDTH-1:0] s_payload_axis_tdata,
    input  logic                      s_payload_axis_tvalid,
    input  logic                      s_payload_axis_tlast,
    output logic                      s_payload_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                      m_tx_axis_tvalid,
    output logic                      m_tx_axis_tlast,
    input  logic                      s_tx_axis_trdy,
    output logic                      o_busy,
    output logic                      o_frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST_PAD = CNT_WIDTH'(MIN_PAYLOAD - 1);
    localparam logic [3:0]           LP_HDR_LAST = 4'd13;

    state_t                r_state;
    logic [3:0]            r_index;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [13:0][7:0]      r_hdr;
    logic                  r_frame_done;

    logic                  w_out_xfer;
    logic                  w_min_reached;
    logic [CNT_WIDTH-1:0]  w_count_inc;
    logic [7:0]            w_hdr_byte;

    // Byte 13 of the packed header is dest[47:40], so the first byte on the wire sits at the top.
    assign w_hdr_byte    = r_hdr[LP_HDR_LAST - r_index];
    assign w_min_reached = (r_count >= LP_LAST_PAD);
    assign w_count_inc   = (r_count == '1) ? r_count : r_count + CNT_WIDTH'(1);
    assign w_out_xfer    = m_tx_axis_tvalid & s_tx_axis_trdy;

    assign s_hdr_ready   = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_frame_done  = r_frame_done;

    // The payload path is a zero-latency pass-through, so the stream outputs decode
    // the current state combinationally instead of being registered.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        m_tx_axis_tdata     = '0;
        m_tx_axis_tvalid    = 1'b0;
        m_tx_axis_tlast     = 1'b0;
        s_payload_axis_trdy = 1'b0;
        case (r_state)
            ST_HEADER: begin
                m_tx_axis_tvalid = 1'b1;
                m_tx_axis_tdata  = AXI_DATA_WIDTH'(w_hdr_byte);
            end
            ST_PAYLOAD: begin
                m_tx_axis_tdata     = s_payload_axis_tdata;
                m_tx_axis_tvalid    = s_payload_axis_tvalid;
                m_tx_axis_tlast     = s_payload_axis_tlast & w_min_reached;
                s_payload_axis_trdy = s_tx_axis_trdy;
            end
            ST_PAD: begin
                m_tx_axis_tvalid = 1'b1;
                m_tx_axis_tlast  = (r_count == LP_LAST_PAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the header registers are reset along with the FSM so an aborted frame
            // leaves no stale address behind; they are ordinary flops, not a memory.
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_count      <= '0;
            r_hdr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_hdr_valid) begin
                        r_hdr   <= {s_hdr_dest_mac, s_hdr_src_mac, s_hdr_eth_type};
                        r_index <= '0;
                        r_state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_out_xfer) begin
                        if (r_index == LP_HDR_LAST) begin
                            r_count <= '0;
                            r_state <= ST_PAYLOAD;
                        end else begin
                            r_index <= r_index + 4'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_out_xfer) begin
                        r_count <= w_count_inc;
                        if (s_payload_axis_tlast) begin
                            if (w_min_reached) begin
                                r_state      <= ST_IDLE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_out_xfer) begin
                        if (r_count == LP_LAST_PAD) begin
                            r_state      <= ST_IDLE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_count <= w_count_inc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
